// File: rtl/axi_lite_master_port_if.sv
// Request/response side and AXI4 master-side channels of axi_lite_master_port.
// The "master" modport is the view of the port block, "slave" is the view of
// the requester plus the interconnect.
interface axi_lite_master_port_if #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_W-1:0]     req_addr;
   logic [3:0]            req_len;
   logic [DATA_W-1:0]     req_wdata;
   logic [DATA_W/8-1:0]   req_wstrb;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic [1:0]            rsp_resp;
   logic                  rsp_last;
   logic                  proto_err;

   logic [ID_W-1:0]       arid;
   logic [ADDR_W-1:0]     araddr;
   logic [3:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arvalid;
   logic                  arready;
   logic [ID_W-1:0]       rid;
   logic [DATA_W-1:0]     rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;
   logic [ID_W-1:0]       awid;
   logic [ADDR_W-1:0]     awaddr;
   logic [3:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awvalid;
   logic                  awready;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;
   logic [ID_W-1:0]       bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   modport master (
      input  req_valid, req_write, req_addr, req_len, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_last, proto_err,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport slave (
      output req_valid, req_write, req_addr, req_len, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_last, proto_err,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_lite_master_port.sv
// AXI4 initiator port: one outstanding transaction, reads of 1..16 beats,
// single-beat writes. Request fields are captured on acceptance and channel
// payloads are driven from those registers, so they stay stable while stalled.
//
// state | meaning
// IDLE  | ready for a new request, no AXI channel active
// AR    | read address presented, waiting for ARREADY
// R     | read beats forwarded to the response side
// AW    | write address presented, waiting for AWREADY
// W     | single write beat presented, waiting for WREADY
// B     | write response forwarded to the response side
module axi_lite_master_port #(
   parameter int ID_W   = 4,
   parameter int MST_ID = 0,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   axi_lite_master_port_if.master bus
);

   typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

   state_t                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q;
   logic [3:0]            len_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W/8-1:0]   wstrb_q;
   logic [3:0]            beat_q;
   logic                  proto_err_q;

   logic                  accept;
   logic                  ar_hs;
   logic                  r_hs;
   logic                  unused_id;

   assign accept = (state_q == S_IDLE) && !rst && bus.req_valid;
   assign ar_hs  = (state_q == S_AR) && bus.arready;
   assign r_hs   = (state_q == S_R) && bus.rvalid && bus.rsp_ready;

   // Response IDs are not checked with a single outstanding transaction.
   assign unused_id = ^{bus.rid, bus.bid};

   assign bus.proto_err = proto_err_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Request capture, read beat counter and RLAST check pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         len_q       <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         beat_q      <= '0;
         proto_err_q <= 1'b0;
      end else begin
         proto_err_q <= r_hs && (bus.rlast != (beat_q == len_q));
         if (accept) begin
            addr_q  <= bus.req_addr;
            len_q   <= bus.req_len;
            wdata_q <= bus.req_wdata;
            wstrb_q <= bus.req_wstrb;
         end
         if (ar_hs)     beat_q <= '0;
         else if (r_hs) beat_q <= beat_q + 4'd1;
      end
   end

   // Next state and all channel/response outputs; payloads are zero outside their state.
   always_comb begin
      state_d       = state_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.rsp_rdata = '0;
      bus.rsp_resp  = 2'b00;
      bus.rsp_last  = 1'b0;
      bus.arid      = '0;
      bus.araddr    = '0;
      bus.arlen     = 4'd0;
      bus.arsize    = 3'b000;
      bus.arburst   = 2'b00;
      bus.arvalid   = 1'b0;
      bus.rready    = 1'b0;
      bus.awid      = '0;
      bus.awaddr    = '0;
      bus.awlen     = 4'd0;
      bus.awsize    = 3'b000;
      bus.awburst   = 2'b00;
      bus.awvalid   = 1'b0;
      bus.wdata     = '0;
      bus.wstrb     = '0;
      bus.wlast     = 1'b0;
      bus.wvalid    = 1'b0;
      bus.bready    = 1'b0;
      case (state_q)
         S_IDLE: begin
            bus.req_ready = !rst;
            if (accept) state_d = bus.req_write ? S_AW : S_AR;
         end
         S_AR: begin
            bus.arvalid = 1'b1;
            bus.arid    = ID_W'(MST_ID);
            bus.araddr  = addr_q;
            bus.arlen   = len_q;
            bus.arsize  = 3'b010;
            bus.arburst = 2'b01;
            if (bus.arready) state_d = S_R;
         end
         S_R: begin
            bus.rready    = bus.rsp_ready;
            bus.rsp_valid = bus.rvalid;
            bus.rsp_rdata = bus.rdata;
            bus.rsp_resp  = bus.rresp;
            bus.rsp_last  = bus.rlast;
            if (r_hs && bus.rlast) state_d = S_IDLE;
         end
         S_AW: begin
            bus.awvalid = 1'b1;
            bus.awid    = ID_W'(MST_ID);
            bus.awaddr  = addr_q;
            bus.awsize  = 3'b010;
            bus.awburst = 2'b01;
            if (bus.awready) state_d = S_W;
         end
         S_W: begin
            bus.wvalid = 1'b1;
            bus.wdata  = wdata_q;
            bus.wstrb  = wstrb_q;
            bus.wlast  = 1'b1;
            if (bus.wready) state_d = S_B;
         end
         S_B: begin
            bus.bready    = bus.rsp_ready;
            bus.rsp_valid = bus.bvalid;
            bus.rsp_resp  = bus.bresp;
            bus.rsp_last  = 1'b1;
            if (bus.bvalid && bus.rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_master_port.sv
// Directed bench for axi_lite_master_port: the bench plays requester and slave,
// driving inputs 1 time unit after each rising edge and checking 1 unit later.
module tb_axi_lite_master_port;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   axi_lite_master_port_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) bus ();

   axi_lite_master_port #(.ID_W(4), .MST_ID(0), .ADDR_W(32), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_req(input logic w, input logic [31:0] a, input logic [3:0] l,
                            input logic [31:0] d, input logic [3:0] s);
      bus.req_valid = 1'b1;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_len   = l;
      bus.req_wdata = d;
      bus.req_wstrb = s;
      #1;
      chk("req_ready_at_issue", bus.req_ready, 1);
      chk("no_valid_in_accept_cycle", {bus.arvalid, bus.awvalid}, 0);
      tick();
      bus.req_valid = 1'b0;
      #1;
   endtask

   initial begin
      int beat;
      n_chk = 0;
      n_err = 0;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_len   = '0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
      bus.rsp_ready = 1'b0;
      bus.arready   = 1'b0;
      bus.rid       = '0;
      bus.rdata     = '0;
      bus.rresp     = '0;
      bus.rlast     = 1'b0;
      bus.rvalid    = 1'b0;
      bus.awready   = 1'b0;
      bus.wready    = 1'b0;
      bus.bid       = '0;
      bus.bresp     = '0;
      bus.bvalid    = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_valids", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rsp_valid}, 0);
      chk("rst_readys", {bus.rready, bus.bready}, 0);
      chk("rst_proto_err", bus.proto_err, 0);
      chk("rst_payload", {bus.araddr, bus.arsize, bus.arburst}, 0);
      rst = 1'b0;
      #1;
      chk("idle_req_ready", bus.req_ready, 1);

      // Read len=0, ARREADY low for 3 cycles
      issue_req(1'b0, 32'h0000_0100, 4'd0, 32'h0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         bus.arready = (i == 3);
         #1;
         chk("t1_arvalid", bus.arvalid, 1);
         chk("t1_araddr", bus.araddr, 32'h0000_0100);
         chk("t1_arlen_size_burst_id", {bus.arlen, bus.arsize, bus.arburst, bus.arid}, {4'd0, 3'b010, 2'b01, 4'd0});
         chk("t1_req_ready_busy", bus.req_ready, 0);
         tick();
      end
      bus.arready   = 1'b0;
      bus.rvalid    = 1'b1;
      bus.rdata     = 32'hDEAD_BEEF;
      bus.rlast     = 1'b1;
      bus.rresp     = 2'b00;
      bus.rsp_ready = 1'b1;
      #1;
      chk("t1_arvalid_dropped", bus.arvalid, 0);
      chk("t1_rsp_valid", bus.rsp_valid, 1);
      chk("t1_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      chk("t1_rsp_last_resp", {bus.rsp_last, bus.rsp_resp}, {1'b1, 2'b00});
      chk("t1_rready", bus.rready, 1);
      tick();
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      #1;
      chk("t1_back_idle", bus.req_ready, 1);
      chk("t1_no_err", bus.proto_err, 0);

      // Burst read len=3, rsp_ready toggling
      issue_req(1'b0, 32'h0001_0000, 4'd3, 32'h0, 4'h0);
      bus.arready = 1'b1;
      #1;
      chk("t2_arlen", bus.arlen, 4'd3);
      chk("t2_araddr", bus.araddr, 32'h0001_0000);
      tick();
      bus.arready = 1'b0;
      beat = 0;
      for (int c = 0; c < 7; c++) begin
         bus.rsp_ready = (c % 2 == 0);
         bus.rvalid    = 1'b1;
         bus.rdata     = 32'hA0 + beat;
         bus.rlast     = (beat == 3);
         #1;
         chk("t2_rready", bus.rready, (c % 2 == 0) ? 1 : 0);
         chk("t2_rsp_valid", bus.rsp_valid, 1);
         chk("t2_rsp_rdata", bus.rsp_rdata, 32'hA0 + beat);
         chk("t2_rsp_last", bus.rsp_last, (beat == 3) ? 1 : 0);
         if (c % 2 == 0) beat++;
         tick();
      end
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      #1;
      chk("t2_back_idle", bus.req_ready, 1);
      chk("t2_no_err", bus.proto_err, 0);

      // Write to WDT, AW strictly before W
      issue_req(1'b1, 32'h1001_0100, 4'd0, 32'h0000_0001, 4'hF);
      chk("t3_awvalid", bus.awvalid, 1);
      chk("t3_wvalid_before_aw", bus.wvalid, 0);
      chk("t3_awaddr", bus.awaddr, 32'h1001_0100);
      chk("t3_awlen_size_burst", {bus.awlen, bus.awsize, bus.awburst}, {4'd0, 3'b010, 2'b01});
      tick();
      bus.awready = 1'b1;
      #1;
      chk("t3_wvalid_in_aw_hs", bus.wvalid, 0);
      chk("t3_awaddr_stable", bus.awaddr, 32'h1001_0100);
      tick();
      bus.awready = 1'b0;
      #1;
      chk("t3_awvalid_dropped", bus.awvalid, 0);
      chk("t3_wvalid", bus.wvalid, 1);
      chk("t3_wdata_wstrb_wlast", {bus.wdata, bus.wstrb, bus.wlast}, {32'h1, 4'hF, 1'b1});
      bus.wready = 1'b1;
      tick();
      bus.wready = 1'b0;
      #1;
      chk("t3_b_wait", {bus.wvalid, bus.rsp_valid, bus.bready}, {1'b0, 1'b0, 1'b1});
      tick();
      bus.bvalid = 1'b1;
      bus.bresp  = 2'b00;
      #1;
      chk("t3_rsp_valid", bus.rsp_valid, 1);
      chk("t3_rsp_last_resp_rdata", {bus.rsp_last, bus.rsp_resp, bus.rsp_rdata}, {1'b1, 2'b00, 32'h0});
      tick();
      bus.bvalid = 1'b0;
      #1;
      chk("t3_back_idle", bus.req_ready, 1);

      // Early RLAST on beat 2 of len=3
      issue_req(1'b0, 32'h0000_0200, 4'd3, 32'h0, 4'h0);
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      bus.rvalid  = 1'b1;
      bus.rdata   = 32'h11;
      bus.rlast   = 1'b0;
      tick();
      bus.rdata = 32'h22;
      bus.rlast = 1'b1;
      #1;
      chk("t4_no_err_yet", bus.proto_err, 0);
      tick();
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      #1;
      chk("t4_proto_err", bus.proto_err, 1);
      chk("t4_idle", bus.req_ready, 1);
      tick();
      chk("t4_err_one_cycle", bus.proto_err, 0);

      // Missing RLAST on len=0: flag, stay in R, flag again on late RLAST
      issue_req(1'b0, 32'h0000_0300, 4'd0, 32'h0, 4'h0);
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      bus.rvalid  = 1'b1;
      bus.rdata   = 32'h33;
      bus.rlast   = 1'b0;
      tick();
      chk("t5_err_missing_last", bus.proto_err, 1);
      chk("t5_still_busy", {bus.req_ready, bus.rready}, {1'b0, 1'b1});
      bus.rlast = 1'b1;
      tick();
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      #1;
      chk("t5_idle_after_late", bus.req_ready, 1);
      chk("t5_err_late_last", bus.proto_err, 1);

      // Reset after beat 1 of a len=3 burst
      issue_req(1'b0, 32'h0000_0400, 4'd3, 32'h0, 4'h0);
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      bus.rvalid  = 1'b1;
      bus.rdata   = 32'h44;
      bus.rlast   = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("t6_req_ready_in_rst", bus.req_ready, 0);
      tick();
      chk("t6_valids_dropped", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rsp_valid}, 0);
      chk("t6_readys_dropped", {bus.rready, bus.bready, bus.req_ready}, 0);
      rst        = 1'b0;
      bus.rvalid = 1'b0;
      #1;
      chk("t6_idle", bus.req_ready, 1);
      issue_req(1'b0, 32'h0000_0500, 4'd0, 32'h0, 4'h0);
      bus.arready = 1'b1;
      #1;
      chk("t6_araddr", {bus.arvalid, bus.araddr}, {1'b1, 32'h0000_0500});
      tick();
      bus.arready = 1'b0;
      bus.rvalid  = 1'b1;
      bus.rdata   = 32'h55;
      bus.rlast   = 1'b1;
      #1;
      chk("t6_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_last}, {1'b1, 32'h55, 1'b1});
      tick();
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      #1;
      chk("t6_done", {bus.req_ready, bus.proto_err}, {1'b1, 1'b0});

      // SLVERR on write forwarded; next request 1 cycle after B handshake
      issue_req(1'b1, 32'h0000_0600, 4'd0, 32'h0000_CAFE, 4'h3);
      bus.awready = 1'b1;
      tick();
      bus.awready = 1'b0;
      bus.wready  = 1'b1;
      tick();
      bus.wready = 1'b0;
      bus.bvalid = 1'b1;
      bus.bresp  = 2'b10;
      #1;
      chk("t7_rsp_resp", bus.rsp_resp, 2'b10);
      chk("t7_busy", bus.req_ready, 0);
      tick();
      bus.bvalid    = 1'b0;
      bus.bresp     = 2'b00;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h0000_0700;
      bus.req_len   = 4'd0;
      #1;
      chk("t7_next_accept", bus.req_ready, 1);
      tick();
      bus.req_valid = 1'b0;
      #1;
      chk("t7_next_ar", {bus.arvalid, bus.araddr}, {1'b1, 32'h0000_0700});
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      bus.rvalid  = 1'b1;
      bus.rlast   = 1'b1;
      bus.rdata   = 32'h77;
      tick();
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      #1;
      chk("t7_final_idle", bus.req_ready, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
